afc_freq_comparator: RTL and testbench

Counter-based frequency comparator that sits directly upstream of the AFC band-search FSM. On each one-cycle `change` request it waits for the VCO to settle on the newly selected band, then counts rising edges of the divided VCO signal over a fixed window of `clk` cycles. It compares the count against a programmable target ± tolerance and returns a one-hot FAST/SLOW/FREEZE verdict with a one-cycle `done` strobe, matching the FSM's `comp_in`/`done` handshake.

---
 rtl/afc_freq_comparator_if.sv | 24 ++
 rtl/afc_freq_comparator.sv | 127 ++++++++++++
 tb/tb_afc_freq_comparator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/afc_freq_comparator_if.sv
// Handshake/measurement bundle between the AFC band-search FSM (master)
// and the counter-based frequency comparator (slave).
interface afc_freq_comparator_if #(
  parameter int unsigned CNT_W = 12
);
  logic             change;
  logic             vco_div;
  logic [CNT_W-1:0] target_cnt;
  logic [CNT_W-1:0] tol_cnt;
  logic [2:0]       comp_out;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] meas_cnt;

  modport master (
    output change, vco_div, target_cnt, tol_cnt,
    input  comp_out, done, busy, meas_cnt
  );

  modport slave (
    input  change, vco_div, target_cnt, tol_cnt,
    output comp_out, done, busy, meas_cnt
  );
endinterface

// File: rtl/afc_freq_comparator.sv
// Counts rising edges of the divided VCO over a fixed window after a settle
// delay and reports FAST/SLOW/FREEZE against target +/- tolerance.
module afc_freq_comparator #(
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WINDOW_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst,
  afc_freq_comparator_if.slave  bus
);
  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [2:0] V_FAST   = 3'b100;
  localparam logic [2:0] V_SLOW   = 3'b010;
  localparam logic [2:0] V_FREEZE = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT} state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] tol_q, tol_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic [2:0]       comp_q, comp_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             prev_q, prev_d;

  logic             rise;
  logic [CNT_W-1:0] edge_inc;
  logic [CNT_W:0]   c_ext, t_ext, d_ext;
  logic [2:0]       verdict;

  always_comb begin
    rise     = bus.vco_div & ~prev_q;
    edge_inc = (rise && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;
    // One extra bit so t+d cannot overflow and t-d is never formed.
    c_ext = {1'b0, edge_inc};
    t_ext = {1'b0, tgt_q};
    d_ext = {1'b0, tol_q};
    if (c_ext > t_ext + d_ext)      verdict = V_FAST;
    else if (c_ext + d_ext < t_ext) verdict = V_SLOW;
    else                            verdict = V_FREEZE;
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    tgt_d   = tgt_q;
    tol_d   = tol_q;
    meas_d  = meas_q;
    comp_d  = comp_q;
    done_d  = 1'b0;
    prev_d  = bus.vco_div;

    // A change in any state (including a COUNT's final cycle) restarts the
    // measurement; the aborted one never reports.
    if (bus.change) begin
      state_d = S_SETTLE;
      tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
      edge_d  = '0;
      tgt_d   = bus.target_cnt;
      tol_d   = bus.tol_cnt;
      comp_d  = '0;
    end else begin
      unique case (state_q)
        S_SETTLE: begin
          if (tmr_q == '0) begin
            state_d = S_COUNT;
            tmr_d   = TMR_W'(WINDOW_CYCLES - 1);
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_COUNT: begin
          edge_d = edge_inc;
          if (tmr_q == '0) begin
            state_d = S_IDLE;
            comp_d  = verdict;
            meas_d  = edge_inc;
            done_d  = 1'b1;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      edge_q  <= '0;
      tgt_q   <= '0;
      tol_q   <= '0;
      meas_q  <= '0;
      comp_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      tgt_q   <= tgt_d;
      tol_q   <= tol_d;
      meas_q  <= meas_d;
      comp_q  <= comp_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      prev_q  <= prev_d;
    end
  end

  assign bus.comp_out = comp_q;
  assign bus.meas_cnt = meas_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_afc_freq_comparator.sv
// Directed bench for afc_freq_comparator: SETTLE=4, WINDOW=100, plus a 4-bit
// counter instance for saturation.
module tb_afc_freq_comparator;
  localparam logic [2:0] V_FAST   = 3'b100;
  localparam logic [2:0] V_SLOW   = 3'b010;
  localparam logic [2:0] V_FREEZE = 3'b001;
  localparam int LAT = 105;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   per = 4;
  int   ph  = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  afc_freq_comparator_if #(.CNT_W(12)) bus();
  afc_freq_comparator_if #(.CNT_W(4))  bus4();

  assign bus4.change     = bus.change;
  assign bus4.vco_div    = bus.vco_div;
  assign bus4.target_cnt = 4'd15;
  assign bus4.tol_cnt    = 4'd0;

  afc_freq_comparator #(.CNT_W(12), .SETTLE_CYCLES(4), .WINDOW_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  afc_freq_comparator #(.CNT_W(4), .SETTLE_CYCLES(4), .WINDOW_CYCLES(100)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Square wave of period per (per=0 -> static low), updated just after each edge.
  initial begin
    bus.vco_div = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (per == 0) begin
        ph = 0;
        bus.vco_div = 1'b0;
      end else begin
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        bus.vco_div = (ph < per / 2);
      end
    end
  end

  task automatic pulse_change(input int t, input int d, output int tc);
    bus.target_cnt = 12'(t);
    bus.tol_cnt    = 12'(d);
    bus.change     = 1'b1;
    tc = cyc;
    wait_cyc(1);
    bus.change = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dc);
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.done === 1'b1) begin
        dc = cyc;
        break;
      end
      wait_cyc(1);
    end
    if (dc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic measure(input string tag, input int t, input int d, input int p,
                         input logic [2:0] exp_v, input int exp_m);
    int tc, dc;
    per = p;
    wait_cyc(8);
    pulse_change(t, d, tc);
    wait_done(tag, dc);
    chk({tag, "_lat"},  32'(dc - tc), 32'(LAT));
    chk({tag, "_comp"}, 32'(bus.comp_out), 32'(exp_v));
    chk({tag, "_meas"}, 32'(bus.meas_cnt), 32'(exp_m));
  endtask

  initial begin
    int tc, tc2, dc, dn0, iter;
    logic [2:0] v;
    bus.change = 1'b0;
    bus.target_cnt = '0;
    bus.tol_cnt = '0;
    per = 4;

    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    chk("rst_comp", 32'(bus.comp_out), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_meas", 32'(bus.meas_cnt), 32'd0);

    // Nominal: change in cycle 10, done only in cycle 115.
    while (cyc < 10) wait_cyc(1);
    pulse_change(25, 1, tc);
    chk("nom_tc", 32'(tc), 32'd10);
    chk("nom_busy", 32'(bus.busy), 32'd1);
    wait_done("nom", dc);
    chk("nom_done_cyc", 32'(dc), 32'd115);
    chk("nom_busy_at_done", 32'(bus.busy), 32'd0);
    chk("nom_comp", 32'(bus.comp_out), 32'(V_FREEZE));
    chk("nom_meas", 32'(bus.meas_cnt), 32'd25);
    wait_cyc(1);
    chk("nom_done_once", 32'(bus.done), 32'd0);
    chk("nom_hold_comp", 32'(bus.comp_out), 32'(V_FREEZE));

    measure("fast_p2", 25, 1, 2, V_FAST, 50);
    chk("sat_meas", 32'(bus4.meas_cnt), 32'd15);
    chk("sat_comp", 32'(bus4.comp_out), 32'(V_FREEZE));
    measure("slow_p5", 25, 1, 5, V_SLOW, 20);
    measure("tol_t24", 24, 1, 4, V_FREEZE, 25);
    measure("tol_t23", 23, 1, 4, V_FAST, 25);
    measure("tol_t27", 27, 1, 4, V_SLOW, 25);
    measure("t0_static", 0, 5, 0, V_FREEZE, 0);

    // Abort: second change 50 cycles after the first yields a single done.
    per = 4;
    wait_cyc(8);
    dn0 = done_cnt;
    pulse_change(25, 1, tc);
    wait_cyc(49);
    pulse_change(25, 1, tc2);
    chk("abort_gap", 32'(tc2 - tc), 32'd50);
    wait_done("abort", dc);
    chk("abort_lat", 32'(dc - tc2), 32'(LAT));
    wait_cyc(20);
    chk("abort_one_done", 32'(done_cnt - dn0), 32'd1);

    // Change coincident with done.
    dn0 = done_cnt;
    pulse_change(27, 1, tc);
    wait_done("coin1", dc);
    chk("coin_old_comp", 32'(bus.comp_out), 32'(V_SLOW));
    pulse_change(25, 1, tc2);
    chk("coin_same_cyc", 32'(tc2), 32'(dc));
    chk("coin_comp_clr", 32'(bus.comp_out), 32'd0);
    chk("coin_busy", 32'(bus.busy), 32'd1);
    chk("coin_done_low", 32'(bus.done), 32'd0);
    wait_done("coin2", dc);
    chk("coin2_lat", 32'(dc - tc2), 32'(LAT));
    chk("coin2_comp", 32'(bus.comp_out), 32'(V_FREEZE));
    wait_cyc(2);
    chk("coin_two_dones", 32'(done_cnt - dn0), 32'd2);

    // Reset mid-COUNT.
    pulse_change(25, 1, tc);
    wait_cyc(30);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("mrst_comp", 32'(bus.comp_out), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_meas", 32'(bus.meas_cnt), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    dn0 = done_cnt;
    wait_cyc(150);
    chk("mrst_no_done", 32'(done_cnt - dn0), 32'd0);

    // Closed loop: FAST -> lengthen period, SLOW -> shorten, until FREEZE.
    per = 2;
    v = 3'b000;
    for (iter = 0; iter < 6; iter++) begin
      wait_cyc(8);
      pulse_change(25, 1, tc);
      wait_done("loop", dc);
      v = bus.comp_out;
      if (v == V_FAST) per = per + 1;
      else if (v == V_SLOW) per = per - 1;
      else break;
    end
    chk("loop_verdict", 32'(v), 32'(V_FREEZE));
    chk("loop_period", 32'(per), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
